// File: rtl/uart_receiver.sv
// UART receive deframer: 16x oversampled start / data (LSB first) / stop, with a one-cycle
// done strobe, a frame-error flag that holds until the next frame and a busy indicator.
module uart_receiver #(
    parameter int unsigned DATA_BITS      = 32,
    parameter int unsigned STP_BITS_TICKS = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_bd_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_error,
    output logic                 o_rx_busy
);

    localparam int unsigned StpClog = $clog2(STP_BITS_TICKS);
    localparam int unsigned TickW   = (StpClog > 4) ? StpClog : 4;
    localparam int unsigned BitW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TickW-1:0] TickMid     = TickW'(7);
    localparam logic [TickW-1:0] TickBitLast = TickW'(15);
    localparam logic [TickW-1:0] TickStpLast = TickW'(STP_BITS_TICKS - 1);
    localparam logic [BitW-1:0]  BitLast     = BitW'(DATA_BITS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e               state_q;
    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic [TickW-1:0]     tick_cnt_q;
    logic [BitW-1:0]      bit_cnt_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 done_q;
    logic                 ferr_q;
    logic                 busy_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= StIdle;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            done_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    // Start edge is taken immediately, independent of the tick phase.
                    if (!rx_s_q) begin
                        state_q    <= StStart;
                        busy_q     <= 1'b1;
                        tick_cnt_q <= '0;
                    end
                end
                StStart: begin
                    if (i_bd_tick) begin
                        if (tick_cnt_q == TickMid) begin
                            if (!rx_s_q) begin
                                state_q    <= StData;
                                tick_cnt_q <= '0;
                                bit_cnt_q  <= '0;
                            end else begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TickW'(1);
                        end
                    end
                end
                StData: begin
                    if (i_bd_tick) begin
                        if (tick_cnt_q == TickBitLast) begin
                            shreg_q    <= {rx_s_q, shreg_q[DATA_BITS-1:1]};
                            tick_cnt_q <= '0;
                            if (bit_cnt_q == BitLast) begin
                                state_q <= StStop;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BitW'(1);
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TickW'(1);
                        end
                    end
                end
                StStop: begin
                    if (i_bd_tick) begin
                        if (tick_cnt_q == TickStpLast) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            data_q  <= shreg_q;
                            ferr_q  <= ~rx_s_q;
                            done_q  <= 1'b1;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TickW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_data        = data_q;
    assign o_rx_done     = done_q;
    assign o_frame_error = ferr_q;
    assign o_rx_busy     = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: three instances (8-bit, 32-bit, 32-bit with 2 stop bits) driven by a
// tick-accurate serial model; received words are checked against a scoreboard queue.
module tb_uart_receiver;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned tick;
    } exp_t;

    typedef struct {
        int          sel;
        logic [31:0] data;
        logic        good;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bd_tick;
    logic        tick_en;
    logic [2:0]  rx;
    logic [7:0]  d8;
    logic [31:0] d32;
    logic [31:0] d32s;
    logic [2:0]  done;
    logic [2:0]  err;
    logic [2:0]  busy;

    int unsigned tick_num;
    int          ph;
    int          n_checks;
    int          n_pass;
    int          n_done [3];
    exp_t        sb0[$];
    exp_t        sb1[$];
    exp_t        sb2[$];

    always #5 clk = ~clk;

    uart_receiver #(.DATA_BITS(8), .STP_BITS_TICKS(16)) u_dut8 (
        .i_clk(clk), .i_reset_n(rst_n), .i_bd_tick(bd_tick), .i_rx(rx[0]),
        .o_data(d8), .o_rx_done(done[0]), .o_frame_error(err[0]), .o_rx_busy(busy[0])
    );

    uart_receiver #(.DATA_BITS(32), .STP_BITS_TICKS(16)) u_dut32 (
        .i_clk(clk), .i_reset_n(rst_n), .i_bd_tick(bd_tick), .i_rx(rx[1]),
        .o_data(d32), .o_rx_done(done[1]), .o_frame_error(err[1]), .o_rx_busy(busy[1])
    );

    uart_receiver #(.DATA_BITS(32), .STP_BITS_TICKS(32)) u_dut32s (
        .i_clk(clk), .i_reset_n(rst_n), .i_bd_tick(bd_tick), .i_rx(rx[2]),
        .o_data(d32s), .o_rx_done(done[2]), .o_frame_error(err[2]), .o_rx_busy(busy[2])
    );

    // One-clock tick every 4 clocks; tick_num names the tick consumed at the next posedge.
    initial begin
        bd_tick  = 1'b0;
        tick_num = 0;
        ph       = 0;
        forever begin
            @(negedge clk);
            ph++;
            if (ph == 4) begin
                ph = 0;
                if (tick_en) begin
                    bd_tick = 1'b1;
                    tick_num++;
                end
            end else begin
                bd_tick = 1'b0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic push(input int s, input exp_t e);
        case (s)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic pop(input int s, output bit ok, output exp_t e);
        ok = 1'b1;
        e  = '{data: 32'h0, err: 1'b0, tick: 0};
        case (s)
            0:       if (sb0.size() == 0) ok = 1'b0; else e = sb0.pop_front();
            1:       if (sb1.size() == 0) ok = 1'b0; else e = sb1.pop_front();
            default: if (sb2.size() == 0) ok = 1'b0; else e = sb2.pop_front();
        endcase
    endtask

    task automatic on_done(input int s);
        exp_t        e;
        bit          ok;
        logic [31:0] d;
        d = (s == 0) ? {24'h0, d8} : (s == 1) ? d32 : d32s;
        n_done[s]++;
        pop(s, ok, e);
        if (!ok) begin
            n_checks++;
            $display("FAIL unexpected_done dut%0d: got data 0x%08h, required no pulse", s, d);
        end else begin
            check($sformatf("data dut%0d", s), d, e.data);
            check($sformatf("frame_error dut%0d", s), {31'h0, err[s]}, {31'h0, e.err});
            check($sformatf("done_tick dut%0d", s), tick_num, e.tick);
            check($sformatf("busy_at_done dut%0d", s), {31'h0, busy[s]}, 32'h0);
        end
    endtask

    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (rst_n && done[s]) on_done(s);
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!bd_tick) @(posedge clk);
        end
    endtask

    task automatic hold(input int s, input logic v, input int n);
        @(negedge clk);
        rx[s] = v;
        wait_ticks(n);
    endtask

    // Start falls just after tick k; the stop-bit decision lands on tick k+8+16*nb+stp.
    task automatic drive_frame(input int s, input logic [31:0] data, input logic good);
        int   nb;
        int   stp;
        exp_t e;
        nb = (s == 0) ? 8 : 32;
        stp = (s == 2) ? 32 : 16;
        wait_ticks(1);
        e.data = (nb == 8) ? (data & 32'hFF) : data;
        e.err  = ~good;
        e.tick = tick_num + 8 + 16 * nb + stp;
        push(s, e);
        hold(s, 1'b0, 16);
        for (int i = 0; i < nb; i++) hold(s, data[i], 16);
        if (good) begin
            hold(s, 1'b1, stp);
        end else begin
            hold(s, 1'b0, 12);
            hold(s, 1'b1, stp - 12);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " d8"}, {24'h0, d8}, 32'h0);
        check({tag, " d32"}, d32, 32'h0);
        check({tag, " d32s"}, d32s, 32'h0);
        check({tag, " done"}, {29'h0, done}, 32'h0);
        check({tag, " err"}, {29'h0, err}, 32'h0);
        check({tag, " busy"}, {29'h0, busy}, 32'h0);
    endtask

    initial begin
        vec_t vecs [7];
        int   nd;

        vecs[0] = '{sel: 0, data: 32'h0000_00A5, good: 1'b1, exp_err: 1'b0};
        vecs[1] = '{sel: 0, data: 32'h0000_003C, good: 1'b0, exp_err: 1'b1};
        vecs[2] = '{sel: 0, data: 32'h0000_0001, good: 1'b1, exp_err: 1'b0};
        vecs[3] = '{sel: 1, data: 32'hDEAD_BEEF, good: 1'b1, exp_err: 1'b0};
        vecs[4] = '{sel: 1, data: 32'h1234_5678, good: 1'b1, exp_err: 1'b0};
        vecs[5] = '{sel: 1, data: 32'h5A5A_0F0F, good: 1'b1, exp_err: 1'b0};
        vecs[6] = '{sel: 1, data: 32'hFFFF_0000, good: 1'b0, exp_err: 1'b1};

        n_checks = 0;
        n_pass   = 0;
        for (int s = 0; s < 3; s++) n_done[s] = 0;
        rst_n   = 1'b0;
        rx      = 3'b111;
        tick_en = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset_initial");
        rst_n = 1'b1;
        wait_ticks(4);

        for (int i = 0; i < 7; i++) begin
            drive_frame(vecs[i].sel, vecs[i].data, vecs[i].good);
            @(negedge clk);
            check($sformatf("err_hold vec%0d", i), {31'h0, err[vecs[i].sel]},
                  {31'h0, vecs[i].exp_err});
        end

        // Reset while idle, after the 32-bit instance holds data and an error.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_idle");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a 32-bit frame: abort with no done.
        nd = n_done[1];
        wait_ticks(1);
        hold(1, 1'b0, 40);
        @(negedge clk);
        check("busy_mid_data", {31'h0, busy[1]}, 32'h1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid_data");
        rx[1] = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        check("no_done_after_abort", n_done[1], nd);
        wait_ticks(20);
        drive_frame(1, 32'h0000_00A5, 1'b1);

        // 5-tick low glitch on the idle line.
        nd = n_done[1];
        wait_ticks(1);
        hold(1, 1'b0, 2);
        @(negedge clk);
        check("glitch_busy_high", {31'h0, busy[1]}, 32'h1);
        wait_ticks(3);
        @(negedge clk);
        rx[1] = 1'b1;
        wait_ticks(5);
        @(negedge clk);
        check("glitch_busy_low", {31'h0, busy[1]}, 32'h0);
        check("glitch_no_done", n_done[1], nd);

        // Two stop bits, with ticks withheld mid-frame.
        fork
            drive_frame(2, 32'hFFFF_FFFF, 1'b1);
            begin
                logic b;
                int   ndh;
                wait_ticks(300);
                tick_en = 1'b0;
                @(negedge clk);
                b   = busy[2];
                ndh = n_done[2];
                repeat (60) @(negedge clk);
                check("freeze_busy", {31'h0, busy[2]}, {31'h0, b});
                check("freeze_busy_high", {31'h0, busy[2]}, 32'h1);
                check("freeze_no_done", n_done[2], ndh);
                tick_en = 1'b1;
            end
        join
        wait_ticks(4);

        check("sb0_empty", sb0.size(), 0);
        check("sb1_empty", sb1.size(), 0);
        check("sb2_empty", sb2.size(), 0);
        check("done_count dut8", n_done[0], 3);
        check("done_count dut32", n_done[1], 5);
        check("done_count dut32s", n_done[2], 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
